dac_sample_drv: RTL and testbench
=================================

DAC_SAMPLE_DRV -- requirements
Module: dac_sample_drv

Interface
REQ-001 SHALL have parameter DEPTH, default 8; sample FIFO depth, power of two.
REQ-002 SHALL have parameter MIDSCALE, default 14'h2000; offset-binary zero code.
REQ-003 SHALL have port ref_clk, input, 1 bit; the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit; synchronous, active-high reset.
REQ-005 SHALL have port s_data, input, 14 bits; two's-complement sample from the upstream sample source.
REQ-006 SHALL have port s_valid, input, 1 bit; s_data is valid.
REQ-007 SHALL have port s_ready, output, 1 bit; the block accepts s_data.
REQ-008 SHALL have port enable, input, 1 bit; enables the output update rate counter.
REQ-009 SHALL have port rate_div, input, 8 bits; output update period is rate_div+1 ref_clk cycles.
REQ-010 SHALL have port dac_data, output, 14 bits; registered offset-binary code to the DAC pins.
REQ-011 SHALL have port dac_update, output, 1 bit; one-cycle pulse, high in the cycle in which dac_data shows a new value.
REQ-012 SHALL have port underrun, output, 1 bit; sticky flag, set when an update tick finds the FIFO empty.
REQ-013 SHALL have port underrun_cnt, output, 16 bits; saturating count of underrun ticks.
REQ-014 SHALL have port fifo_level, output, 4 bits; FIFO occupancy, 0..DEPTH.

Function
REQ-015 SHALL accept a sample on a rising edge where s_valid && s_ready; s_ready = !full && !reset, combinational from registered state.
REQ-016 SHALL, when full, leave s_ready low even if a pop occurs that cycle; s_ready rises the cycle after the pop.
REQ-017 SHALL implement the rate counter as: enable low -> counter held at 0, no tick; enable high -> tick when cnt >= rate_div, then cnt <= 0, else cnt <= cnt+1.
REQ-018 SHALL apply a mid-run rate_div change on the next comparison; if cnt already exceeds the new value, it ticks immediately.
REQ-019 SHALL, on a tick with FIFO non-empty, pop the head word d and register dac_data <= {~d[13], d[12:0]}, with dac_update=1 in the following cycle (aligned with the new dac_data).
REQ-020 SHALL, on a tick with FIFO empty, hold dac_data, keep dac_update low, set underrun, and increment underrun_cnt, saturating at 16'hFFFF.
REQ-021 SHALL make a word pushed at edge N into an empty FIFO eligible for a pop from edge N+1 onward (no same-edge fall-through).
REQ-022 SHALL, on a simultaneous push and pop, leave fifo_level unchanged and preserve FIFO order.
REQ-023 SHALL wrap the FIFO read/write pointers modulo DEPTH, with full/empty derived from an extra pointer bit or from level.
REQ-024 SHALL hold dac_data at its last value indefinitely while enable=0.

Reset
REQ-025 SHALL, on reset high at a rising edge, set: dac_data=MIDSCALE, dac_update=0, underrun=0, underrun_cnt=0, fifo_level=0, pointers=0, rate counter=0.
REQ-026 SHALL discard FIFO contents on reset mid-operation; no pop and no push occurs on a reset edge.
REQ-027 SHALL drive s_ready low while reset is high and 1 in the first cycle after release.

Verification
REQ-028 Reset: assert reset 2 cycles -> dac_data=0x2000, fifo_level=0, underrun=0, underrun_cnt=0, s_ready=0 during reset and 1 after.
REQ-029 Conversion: rate_div=0, enable=1, push 0x0000, 0x1FFF, 0x2000, 0x3FFF -> dac_data 0x2000, 0x3FFF, 0x0000, 0x1FFF on consecutive dac_update pulses.
REQ-030 Full: enable=0, push 9 words with s_valid held -> fifo_level=8, s_ready=0 after 8th accept, 9th held; then enable=1, rate_div=0 -> 9th accepted one cycle after first pop.
REQ-031 Underrun: enable=1, rate_div=3, FIFO empty 16 cycles -> underrun_cnt=4, underrun=1, dac_data unchanged, no dac_update.
REQ-032 Rate: rate_div=4, FIFO kept non-empty -> dac_update pulses exactly every 5 cycles; change rate_div to 1 mid-count at cnt=3 -> tick next cycle, then every 2 cycles.
REQ-033 Reset mid-operation: fifo_level=5, enable=1, assert reset 1 cycle -> fifo_level=0, dac_data=0x2000, underrun_cnt=0; subsequent pushes replay correctly.

Source files
------------

// File: rtl/dac_sample_drv.sv
// dac_sample_drv: buffers two's-complement samples in a small FIFO and
// replays them to a DAC at a programmable update rate, converting each
// sample to offset-binary. Empty-FIFO update ticks are flagged and counted.
module dac_sample_drv #(
   parameter int          DEPTH    = 8,
   parameter logic [13:0] MIDSCALE = 14'h2000
) (
   input  logic        ref_clk,
   input  logic        reset,
   input  logic [13:0] s_data,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic        enable,
   input  logic [7:0]  rate_div,
   output logic [13:0] dac_data,
   output logic        dac_update,
   output logic        underrun,
   output logic [15:0] underrun_cnt,
   output logic [3:0]  fifo_level
);

   // DEPTH is a power of two, so AW-bit pointers wrap modulo DEPTH naturally
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [13:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [3:0]    level_q, level_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [13:0]   dac_data_q, dac_data_d;
   logic          dac_update_q, dac_update_d;
   logic          underrun_q, underrun_d;
   logic [15:0]   underrun_cnt_q, underrun_cnt_d;

   logic          full, empty, tick, push, pop;
   logic [13:0]   head;

   // Occupancy comes from the registered level, so a word written on one
   // edge can only be popped from the following edge onward.
   assign full    = (level_q == 4'(DEPTH));
   assign empty   = (level_q == 4'd0);
   assign s_ready = !full && !reset;
   assign tick    = enable && (cnt_q >= rate_div);
   assign push    = s_valid && s_ready;
   assign pop     = tick && !empty && !reset;
   assign head    = mem_q[rd_ptr_q];

   // Next-state logic for the rate counter, FIFO pointers and DAC outputs
   always_comb begin
      cnt_d          = cnt_q;
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      level_d        = level_q;
      dac_data_d     = dac_data_q;
      dac_update_d   = 1'b0;
      underrun_d     = underrun_q;
      underrun_cnt_d = underrun_cnt_q;

      if (!enable) begin
         cnt_d = 8'd0;
      end else if (tick) begin
         cnt_d = 8'd0;
      end else begin
         cnt_d = cnt_q + 8'd1;
      end

      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end

      if (pop) begin
         rd_ptr_d     = rd_ptr_q + AW'(1);
         // Inverting the sign bit maps two's complement onto offset binary
         dac_data_d   = {~head[13], head[12:0]};
         dac_update_d = 1'b1;
      end else if (tick) begin
         underrun_d = 1'b1;
         if (underrun_cnt_q != 16'hFFFF) begin
            underrun_cnt_d = underrun_cnt_q + 16'd1;
         end
      end

      case ({push, pop})
         2'b10:   level_d = level_q + 4'd1;
         2'b01:   level_d = level_q - 4'd1;
         default: level_d = level_q;
      endcase
   end

   // State register; reset discards FIFO contents and parks the DAC at midscale
   always_ff @(posedge ref_clk) begin
      if (reset) begin
         cnt_q          <= 8'd0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         level_q        <= 4'd0;
         dac_data_q     <= MIDSCALE;
         dac_update_q   <= 1'b0;
         underrun_q     <= 1'b0;
         underrun_cnt_q <= 16'd0;
      end else begin
         cnt_q          <= cnt_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         level_q        <= level_d;
         dac_data_q     <= dac_data_d;
         dac_update_q   <= dac_update_d;
         underrun_q     <= underrun_d;
         underrun_cnt_q <= underrun_cnt_d;
      end
   end

   // Sample storage; push is already qualified by reset through s_ready
   always_ff @(posedge ref_clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= s_data;
      end
   end

   assign dac_data     = dac_data_q;
   assign dac_update   = dac_update_q;
   assign underrun     = underrun_q;
   assign underrun_cnt = underrun_cnt_q;
   assign fifo_level   = level_q;

endmodule

// File: tb/tb_dac_sample_drv.sv
// Testbench for dac_sample_drv: a spec-level reference model predicts every
// output each cycle; converted samples go into a scoreboard that a monitor
// drains whenever the DUT pulses dac_update.
module tb_dac_sample_drv;

   localparam int DEPTH = 8;

   logic        ref_clk = 1'b0;
   logic        reset   = 1'b1;
   logic [13:0] s_data  = 14'd0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic        enable  = 1'b0;
   logic [7:0]  rate_div = 8'd0;
   logic [13:0] dac_data;
   logic        dac_update;
   logic        underrun;
   logic [15:0] underrun_cnt;
   logic [3:0]  fifo_level;

   dac_sample_drv #(.DEPTH(DEPTH), .MIDSCALE(14'h2000)) dut (
      .ref_clk      (ref_clk),
      .reset        (reset),
      .s_data       (s_data),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .enable       (enable),
      .rate_div     (rate_div),
      .dac_data     (dac_data),
      .dac_update   (dac_update),
      .underrun     (underrun),
      .underrun_cnt (underrun_cnt),
      .fifo_level   (fifo_level)
   );

   always #5 ref_clk = ~ref_clk;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state
   logic [13:0] m_fifo[$];
   logic [13:0] sb[$];
   logic [13:0] stim[$];
   int          m_cnt      = 0;
   logic [13:0] m_dac      = 14'h2000;
   bit          m_upd      = 1'b0;
   bit          m_und      = 1'b0;
   int          m_ucnt     = 0;
   bit          m_started  = 1'b0;
   bit          m_accepted = 1'b0;
   int          gap_pct    = 0;

   function automatic void chk(string name, longint act, longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference model: applies the block's rules at every rising edge
   initial begin
      forever begin
         @(posedge ref_clk);
         if (reset) begin
            m_fifo.delete();
            m_cnt      = 0;
            m_dac      = 14'h2000;
            m_upd      = 1'b0;
            m_und      = 1'b0;
            m_ucnt     = 0;
            m_accepted = 1'b0;
            m_started  = 1'b1;
         end else begin
            bit          rdy, psh, tck, pp;
            logic [13:0] d;
            rdy = (m_fifo.size() < DEPTH);
            psh = s_valid && rdy;
            tck = enable && (m_cnt >= int'(rate_div));
            pp  = tck && (m_fifo.size() > 0);
            m_upd      = pp;
            m_accepted = psh;
            if (pp) begin
               d     = m_fifo.pop_front();
               m_dac = d + 14'h2000;   // signed value + half range, mod 2^14
               sb.push_back(m_dac);
            end else if (tck) begin
               m_und = 1'b1;
               if (m_ucnt < 65535) m_ucnt++;
            end
            if (psh) m_fifo.push_back(s_data);
            if (!enable || tck) m_cnt = 0;
            else m_cnt++;
         end
      end
   end

   // Monitor: compares every output on the falling edge
   initial begin
      forever begin
         @(negedge ref_clk);
         if (m_started) begin
            chk("s_ready", s_ready, (!reset && m_fifo.size() < DEPTH));
            chk("fifo_level", fifo_level, m_fifo.size());
            chk("dac_update", dac_update, m_upd);
            chk("dac_data", dac_data, m_dac);
            chk("underrun", underrun, m_und);
            chk("underrun_cnt", underrun_cnt, m_ucnt);
            if (dac_update) begin
               if (sb.size() == 0) begin
                  chk("sb_unexpected_update", 1, 0);
               end else begin
                  logic [13:0] e;
                  e = sb.pop_front();
                  chk("update_data", dac_data, e);
                  $display("update dac_data=%h expected=%h t=%0t", dac_data, e, $time);
               end
            end
         end
      end
   end

   // Source driver: presents queued samples, optionally with random gaps
   initial begin
      forever begin
         @(posedge ref_clk);
         #1;
         if (m_accepted && stim.size() > 0) void'(stim.pop_front());
         if (stim.size() > 0 && ($urandom_range(99) >= gap_pct)) begin
            s_valid = 1'b1;
            s_data  = stim[0];
         end else begin
            s_valid = 1'b0;
         end
      end
   end

   task automatic step(int n);
      repeat (n) @(posedge ref_clk);
      #1;
   endtask

   task automatic wait_stim(string name, int budget);
      int n = 0;
      while (stim.size() > 0 && n < budget) begin
         step(1);
         n++;
      end
      chk(name, stim.size(), 0);
   endtask

   task automatic wait_fifo_empty(string name, int budget);
      int n = 0;
      while (m_fifo.size() > 0 && n < budget) begin
         step(1);
         n++;
      end
      chk(name, m_fifo.size(), 0);
   endtask

   task automatic do_reset(int n);
      reset = 1'b1;
      step(n);
      reset = 1'b0;
   endtask

   initial begin
      int n;
      // Reset held for two edges
      step(2);
      reset = 1'b0;
      step(3);
      chk("post_reset_dac", dac_data, 14'h2000);

      // Conversion of the four corner codes
      rate_div = 8'd0;
      stim.push_back(14'h0000);
      stim.push_back(14'h1FFF);
      stim.push_back(14'h2000);
      stim.push_back(14'h3FFF);
      wait_stim("conv_push_timeout", 50);
      enable = 1'b1;
      wait_fifo_empty("conv_drain_timeout", 50);
      step(2);
      chk("conv_last_dac", dac_data, 14'h1FFF);
      enable = 1'b0;

      // Full FIFO with the ninth word held back
      do_reset(2);
      for (int i = 0; i < 9; i++) stim.push_back(14'($urandom));
      step(15);
      chk("full_level", fifo_level, 8);
      chk("full_ready", s_ready, 0);
      enable = 1'b1;
      wait_stim("full_push_timeout", 50);
      wait_fifo_empty("full_drain_timeout", 50);
      enable = 1'b0;

      // Underrun on an empty FIFO
      do_reset(1);
      step(2);
      rate_div = 8'd3;
      enable   = 1'b1;
      step(16);
      chk("underrun_16", underrun_cnt, 4);
      chk("underrun_dac_held", dac_data, 14'h2000);
      enable = 1'b0;

      // Update period and mid-count rate change
      do_reset(1);
      rate_div = 8'd4;
      for (int i = 0; i < 14; i++) stim.push_back(14'($urandom));
      step(10);
      enable = 1'b1;
      step(12);
      n = 0;
      while (m_cnt != 3 && n < 20) begin
         step(1);
         n++;
      end
      chk("rate_cnt3_timeout", m_cnt, 3);
      rate_div = 8'd1;
      step(10);
      enable = 1'b0;
      stim.delete();

      // Reset with five words buffered, then replay
      do_reset(1);
      for (int i = 0; i < 5; i++) stim.push_back(14'($urandom));
      wait_stim("mid_push_timeout", 30);
      step(1);
      chk("mid_level5", fifo_level, 5);
      enable = 1'b1;
      do_reset(1);
      chk("mid_level0", fifo_level, 0);
      rate_div = 8'd0;
      for (int i = 0; i < 4; i++) stim.push_back(14'($urandom));
      wait_stim("replay_push_timeout", 50);
      wait_fifo_empty("replay_drain_timeout", 50);

      // Randomized traffic
      for (int it = 0; it < 300; it++) begin
         rate_div = 8'($urandom_range(3));
         enable   = ($urandom_range(99) < 80);
         gap_pct  = $urandom_range(60);
         if (stim.size() < 12) begin
            for (int k = 0; k < int'($urandom_range(4)); k++) stim.push_back(14'($urandom));
         end
         if ($urandom_range(99) < 2) do_reset(1);
         step($urandom_range(1, 8));
      end
      gap_pct = 0;

      // Saturation of the underrun counter
      enable   = 1'b1;
      rate_div = 8'd0;
      wait_stim("sat_flush_timeout", 200);
      do_reset(1);
      step(65540);
      chk("underrun_sat", underrun_cnt, 16'hFFFF);
      enable = 1'b0;
      step(2);

      chk("sb_leftover", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
